// File: rtl/mips_seq_pkg.sv
// Shared types for the multi-cycle MIPS sequencer.
// State encoding, PC source selects and syscall codes.
package mips_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  localparam logic [31:0] EXIT_CODE = 32'd10;

  // JR beats J beats a taken branch; otherwise fall through.
  function automatic logic [1:0] pc_sel(
    input logic jr,
    input logic j,
    input logic br,
    input logic cond
  );
    if (jr)
      return PCSRC_JR;
    else if (j)
      return PCSRC_J;
    else if (br && cond)
      return PCSRC_BR;
    else
      return PCSRC_SEQ;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; tc flags the last allowed
// wait cycle so the FSM can bail out on that same cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (en)
      count <= count + 16'd1;
  end

  assign tc = (count == 16'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with
// memory handshake, wait timeout, halt and retire count.
module mc_sequencer
  import mips_seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             dec_valid,
  input  logic             dec_regwrite,
  input  logic             dec_memread,
  input  logic             dec_memwrite,
  input  logic             dec_jump,
  input  logic             dec_branch,
  input  logic             dec_jumpreg,
  input  logic             dec_syscall,
  input  logic             dec_exit,
  input  logic             br_cond,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_isel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  state_t next;
  logic   commit;
  logic   in_mem;
  logic   tc;

  assign in_mem = (state == S_FETCH) || (state == S_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(!in_mem),
    .en   (in_mem && !mem_ack),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next;
  end

  always_ff @(posedge clk) begin
    if (reset)
      retired <= '0;
    else if (commit)
      retired <= retired + 1'b1;
  end

  always_comb begin
    next     = state;
    commit   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_isel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PCSRC_SEQ;
    rf_we    = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run)
          next = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_isel = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          next  = S_DECODE;
        end else if (tc) begin
          next = S_ERR;
        end
      end
      S_DECODE: begin
        if (!dec_valid)
          next = S_ERR;
        else if (dec_syscall && dec_exit)
          next = S_HALT;
        else
          next = S_EXEC;
      end
      S_EXEC: begin
        if (dec_memread || dec_memwrite)
          next = S_MEM;
        else if (dec_regwrite)
          next = S_WB;
        else
          commit = 1'b1;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec_memwrite;
        if (mem_ack) begin
          if (dec_memread)
            next = S_WB;
          else
            commit = 1'b1;
        end else if (tc) begin
          next = S_ERR;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        commit = 1'b1;
      end
      S_HALT: halted = 1'b1;
      S_ERR:  illegal = 1'b1;
    endcase
    // Retiring cycle: steer the PC and pick up run again.
    if (commit) begin
      pc_we  = 1'b1;
      pc_src = pc_sel(dec_jumpreg, dec_jump,
                      dec_branch, br_cond);
      next   = run ? S_FETCH : S_IDLE;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-instruction cycle
// expectations from a transaction model, checked every cycle.
module tb_mc_sequencer;

  localparam int CNT_W = 32;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic dec_valid = 1'b0;
  logic dec_regwrite = 1'b0;
  logic dec_memread = 1'b0;
  logic dec_memwrite = 1'b0;
  logic dec_jump = 1'b0;
  logic dec_branch = 1'b0;
  logic dec_jumpreg = 1'b0;
  logic dec_syscall = 1'b0;
  logic dec_exit = 1'b0;
  logic br_cond = 1'b0;
  logic mem_ack = 1'b0;
  logic mem_req, mem_we, mem_isel, ir_we, pc_we;
  logic [1:0] pc_src;
  logic rf_we, halted, illegal;
  logic [CNT_W-1:0] retired;

  mc_sequencer #(
    .CNT_W(CNT_W),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .dec_valid(dec_valid), .dec_regwrite(dec_regwrite),
    .dec_memread(dec_memread), .dec_memwrite(dec_memwrite),
    .dec_jump(dec_jump), .dec_branch(dec_branch),
    .dec_jumpreg(dec_jumpreg), .dec_syscall(dec_syscall),
    .dec_exit(dec_exit), .br_cond(br_cond),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_isel(mem_isel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .rf_we(rf_we), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, mem_we, mem_isel, ir_we, pc_we;
    logic [1:0] pc_src;
    logic rf_we, halted, illegal;
    logic [CNT_W-1:0] retired;
  } exp_t;

  typedef struct packed {
    logic valid, rw, mr, mw, j, br, jr, sc, ex, cond;
  } ins_t;

  localparam ins_t ADD  = '{valid:1'b1, rw:1'b1, default:1'b0};
  localparam ins_t LW   = '{valid:1'b1, rw:1'b1, mr:1'b1, default:1'b0};
  localparam ins_t SW   = '{valid:1'b1, mw:1'b1, default:1'b0};
  localparam ins_t BNE1 = '{valid:1'b1, br:1'b1, cond:1'b1, default:1'b0};
  localparam ins_t BNE0 = '{valid:1'b1, br:1'b1, default:1'b0};
  localparam ins_t JAL  = '{valid:1'b1, rw:1'b1, j:1'b1, default:1'b0};
  localparam ins_t JMP  = '{valid:1'b1, j:1'b1, default:1'b0};
  localparam ins_t JR   = '{valid:1'b1, jr:1'b1, default:1'b0};
  localparam ins_t SYS  = '{valid:1'b1, sc:1'b1, default:1'b0};
  localparam ins_t EXIT = '{valid:1'b1, sc:1'b1, ex:1'b1, default:1'b0};
  localparam ins_t BAD  = '{default:1'b0};

  exp_t q[$];
  exp_t ce, ca;
  int checks = 0;
  int fails = 0;
  logic [CNT_W-1:0] model_ret = '0;
  int len;

  always @(negedge clk) begin
    #2;
    if (q.size() > 0) begin
      ce = q.pop_front();
      ca = {mem_req, mem_we, mem_isel, ir_we, pc_we, pc_src,
            rf_we, halted, illegal, retired};
      checks++;
      if (ca !== ce) begin
        fails++;
        $display("FAIL outputs t=%0t got=%h want=%h", $time, ca, ce);
      end
    end
  end

  function automatic exp_t base();
    exp_t e = '0;
    e.retired = model_ret;
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic r,
                     input logic ack, input ins_t c, input exp_t e);
    @(negedge clk);
    reset = rst;
    run = r;
    mem_ack = ack;
    {dec_valid, dec_regwrite, dec_memread, dec_memwrite, dec_jump,
     dec_branch, dec_jumpreg, dec_syscall, dec_exit, br_cond} = c;
    q.push_back(e);
  endtask

  task automatic commit(inout exp_t e, input ins_t c);
    e.pc_we = 1'b1;
    if (c.jr) e.pc_src = 2'd3;
    else if (c.j) e.pc_src = 2'd2;
    else if (c.br && c.cond) e.pc_src = 2'd1;
    else e.pc_src = 2'd0;
    model_ret = model_ret + 1'b1;
  endtask

  task automatic err_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = base();
      e.illegal = 1'b1;
      cyc(0, 1, 1, '0, e);
    end
  endtask

  task automatic idle(input logic r);
    cyc(0, r, 0, '0, base());
  endtask

  task automatic rst_cycle(input exp_t e);
    cyc(1, 0, 0, '0, e);
    model_ret = '0;
  endtask

  // One memory access: w wait cycles then ack, unless the
  // wait budget of TMO cycles runs out first.
  task automatic phase(input ins_t c, input logic r, input int w,
                       input logic f, input logic fin, output logic to);
    exp_t e;
    to = 1'b0;
    for (int i = 0; i <= w; i++) begin
      e = base();
      e.mem_req = 1'b1;
      e.mem_isel = f;
      e.mem_we = !f && c.mw;
      if (i == w) begin
        if (f) e.ir_we = 1'b1;
        else if (fin) commit(e, c);
        cyc(0, f ? 1'b1 : r, 1, c, e);
        return;
      end
      cyc(0, f ? 1'b1 : r, 0, c, e);
      if (i == TMO - 1) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic instr(input ins_t c, input int fw, input int mw,
                       input logic r, output int n);
    exp_t e;
    logic to;
    logic mem;
    n = 0;
    mem = c.mr | c.mw;
    phase(c, r, fw, 1, 0, to);
    n += to ? TMO : fw + 1;
    if (to) begin err_cycles(3); return; end
    cyc(0, r, 0, c, base());
    n++;
    if (!c.valid) begin err_cycles(3); return; end
    if (c.sc && c.ex) return;
    e = base();
    if (!mem && !c.rw) commit(e, c);
    cyc(0, r, 0, c, e);
    n++;
    if (mem) begin
      phase(c, r, mw, 0, !c.mr, to);
      n += to ? TMO : mw + 1;
      if (to) begin err_cycles(3); return; end
    end
    if (c.mr || (!mem && c.rw)) begin
      e = base();
      e.rf_we = 1'b1;
      commit(e, c);
      cyc(0, r, 0, c, e);
      n++;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_late(input string nm, input logic [63:0] want);
    logic [63:0] got;
    @(posedge clk);
    #1;
    unique case (nm)
      "halted":  got = 64'(halted);
      "illegal": got = 64'(illegal);
      "mem_req": got = 64'(mem_req);
      default:   got = 64'(retired);
    endcase
    chk(nm, got, want);
  endtask

  initial begin : main
    exp_t e;
    repeat (2) @(posedge clk);
    cyc(1, 0, 0, '0, base());
    idle(0);
    chk_late("retired_reset", 0);

    idle(1);
    instr(ADD, 0, 0, 1, len);  chk("len_add", len, 4);
    chk_late("retired_add", 1);
    instr(LW, 0, 3, 1, len);   chk("len_lw", len, 8);
    instr(BNE1, 0, 0, 1, len); chk("len_bne_t", len, 3);
    instr(BNE0, 0, 0, 1, len); chk("len_bne_n", len, 3);
    instr(JAL, 0, 0, 1, len);  chk("len_jal", len, 4);
    instr(JR, 0, 0, 1, len);   chk("len_jr", len, 3);
    instr(SYS, 0, 0, 1, len);  chk("len_nop_sys", len, 3);
    instr(JMP, 3, 0, 1, len);  chk("len_j_ackwin", len, 6);
    instr(SW, 0, 2, 0, len);   chk("len_sw", len, 6);
    chk_late("retired_sw", 9);
    repeat (3) idle(0);
    chk_late("mem_req", 0);
    idle(1);
    instr(ADD, 1, 0, 1, len);  chk("len_add_w", len, 5);
    chk_late("retired_add2", 10);

    instr(EXIT, 0, 0, 1, len); chk("len_exit", len, 2);
    for (int i = 0; i < 20; i++) begin
      e = base();
      e.halted = 1'b1;
      cyc(0, 1, 1, '0, e);
    end
    chk_late("halted", 1);
    e = base(); e.halted = 1'b1;
    rst_cycle(e);
    idle(0);
    chk_late("halted", 0);
    chk_late("retired_after_rst", 0);

    idle(1);
    instr(ADD, 10, 0, 1, len); chk("len_fetch_to", len, TMO);
    chk_late("illegal", 1);
    e = base(); e.illegal = 1'b1;
    rst_cycle(e);
    idle(0);
    chk_late("illegal", 0);

    idle(1);
    instr(LW, 0, 10, 1, len);  chk("len_mem_to", len, 3 + TMO);
    e = base(); e.illegal = 1'b1;
    rst_cycle(e);

    idle(1);
    instr(BAD, 0, 0, 1, len);  chk("len_bad", len, 2);
    e = base(); e.illegal = 1'b1;
    rst_cycle(e);

    idle(1);
    e = base(); e.mem_req = 1'b1; e.mem_isel = 1'b1;
    cyc(0, 1, 0, ADD, e);
    rst_cycle(e);
    idle(0);
    chk_late("mem_req", 0);

    @(negedge clk);
    #5;
    chk("queue_drained", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
